// File: rtl/tb_mon_pkg.sv
// Shared types and helpers for the multi-channel pass/fail/timeout monitor.
// State encoding is the externally visible 3-bit state value.
package tb_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } mon_state_e;

   localparam int SAT_MAX_W = 64;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int w);
      logic [SAT_MAX_W-1:0] top;
      top = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
      return (v >= top) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/tb_multi_pass_monitor_if.sv
// Per-channel commit, fetch and tohost signals observed by the monitor.
// Fetch handshake: a transfer is one cycle with ifu_valid and ifu_ready both high; the monitor only observes.
interface tb_multi_pass_monitor_if #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 32
);
   logic                   start;
   logic [N_CH-1:0]        cmt_valid;
   logic [N_CH-1:0]        tohost_wr;
   logic [N_CH*DATA_W-1:0] tohost_data;
   logic [N_CH-1:0]        ifu_valid;
   logic [N_CH-1:0]        ifu_ready;

   modport master (output start, cmt_valid, tohost_wr, tohost_data, ifu_valid, ifu_ready);
   modport slave  (input  start, cmt_valid, tohost_wr, tohost_data, ifu_valid, ifu_ready);
endinterface

// File: rtl/tb_mon_chan.sv
// One monitored channel: sticky pass flag, retire/fetch/tohost counters and first-write timestamp.
// Emits pass_evt/fail_evt combinationally for the top-level run FSM.
module tb_mon_chan
   import tb_mon_pkg::*;
#(
   parameter int          CNT_W     = 32,
   parameter int          DATA_W    = 32,
   parameter int unsigned PASS_CODE = 1
) (
   input  logic              tb_clk,
   input  logic              tb_rst_n,
   input  logic              run,
   input  logic              cmt_valid,
   input  logic              tohost_wr,
   input  logic [DATA_W-1:0] tohost_data,
   input  logic              ifu_valid,
   input  logic              ifu_ready,
   input  logic [CNT_W-1:0]  run_cycles,
   output logic              passed,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic [CNT_W-1:0]  tohost_cnt,
   output logic [CNT_W-1:0]  tohost_cycle,
   output logic              pass_evt,
   output logic              fail_evt
);

   logic qual;
   logic seen;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
      return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
   endfunction

   assign qual     = run & tohost_wr & cmt_valid;
   assign pass_evt = qual && (tohost_data == DATA_W'(PASS_CODE));
   assign fail_evt = qual && (tohost_data != DATA_W'(PASS_CODE)) && (tohost_data != '0);

   // passed is registered, so the write cycle that sets it still counts.
   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         passed       <= 1'b0;
         seen         <= 1'b0;
         retire_cnt   <= '0;
         fetch_cnt    <= '0;
         tohost_cnt   <= '0;
         tohost_cycle <= '0;
      end else if (run) begin
         if (!passed) begin
            if (cmt_valid)              retire_cnt <= inc(retire_cnt);
            if (ifu_valid && ifu_ready) fetch_cnt  <= inc(fetch_cnt);
         end
         if (qual) begin
            tohost_cnt <= inc(tohost_cnt);
            if (!seen) begin
               tohost_cycle <= run_cycles;
               seen         <= 1'b1;
            end
         end
         if (pass_evt) passed <= 1'b1;
      end
   end

endmodule

// File: rtl/tb_multi_pass_monitor.sv
// Testbench run monitor: classifies a multi-core run as PASS, FAIL or TIMEOUT
// from tohost writes and gathers per-channel performance counters.
module tb_multi_pass_monitor
   import tb_mon_pkg::*;
#(
   parameter int          N_CH        = 2,
   parameter int          CNT_W       = 32,
   parameter int          DATA_W      = 32,
   parameter int unsigned PASS_CODE   = 1,
   parameter int unsigned TIMEOUT_CYC = 1000000,
   localparam int         FCH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    tb_clk,
   input  logic                    tb_rst_n,
   tb_multi_pass_monitor_if.slave  mon,
   output logic [2:0]              state,
   output logic                    done,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [CNT_W-1:0]        run_cycles,
   output logic [N_CH-1:0]         ch_passed,
   output logic [N_CH*CNT_W-1:0]   retire_cnt,
   output logic [N_CH*CNT_W-1:0]   fetch_cnt,
   output logic [N_CH*CNT_W-1:0]   tohost_cnt,
   output logic [N_CH*CNT_W-1:0]   tohost_cycle,
   output logic [DATA_W-1:0]       fail_code,
   output logic [FCH_W-1:0]        fail_ch
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

   mon_state_e        st_q, st_d;
   logic              run;
   logic              to_hit;
   logic [N_CH-1:0]   passed, pass_evt, fail_evt;
   logic [FCH_W-1:0]  fail_idx;
   logic [DATA_W-1:0] fail_data;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
      return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
   endfunction

   assign run       = (st_q == ST_RUN);
   assign to_hit    = (TIMEOUT_CYC != 0) && (run_cycles == TO_LAST);
   assign state     = st_q;
   assign done      = (st_q == ST_PASS) || (st_q == ST_FAIL) || (st_q == ST_TIMEOUT);
   assign ch_passed = passed;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      tb_mon_chan #(
         .CNT_W     (CNT_W),
         .DATA_W    (DATA_W),
         .PASS_CODE (PASS_CODE)
      ) u_chan (
         .tb_clk       (tb_clk),
         .tb_rst_n     (tb_rst_n),
         .run          (run),
         .cmt_valid    (mon.cmt_valid[c]),
         .tohost_wr    (mon.tohost_wr[c]),
         .tohost_data  (mon.tohost_data[c*DATA_W +: DATA_W]),
         .ifu_valid    (mon.ifu_valid[c]),
         .ifu_ready    (mon.ifu_ready[c]),
         .run_cycles   (run_cycles),
         .passed       (passed[c]),
         .retire_cnt   (retire_cnt[c*CNT_W +: CNT_W]),
         .fetch_cnt    (fetch_cnt[c*CNT_W +: CNT_W]),
         .tohost_cnt   (tohost_cnt[c*CNT_W +: CNT_W]),
         .tohost_cycle (tohost_cycle[c*CNT_W +: CNT_W]),
         .pass_evt     (pass_evt[c]),
         .fail_evt     (fail_evt[c])
      );
   end

   // Scan high to low so the lowest failing channel is the one captured.
   always_comb begin
      fail_idx  = '0;
      fail_data = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (fail_evt[c]) begin
            fail_idx  = FCH_W'(c);
            fail_data = mon.tohost_data[c*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (mon.start) st_d = ST_RUN;
         ST_RUN: begin
            if (|fail_evt)                st_d = ST_FAIL;
            else if (&(passed | pass_evt)) st_d = ST_PASS;
            else if (to_hit)              st_d = ST_TIMEOUT;
         end
         default: st_d = st_q;
      endcase
   end

   // run_cycles holds on the deciding cycle, so a timeout reports TIMEOUT_CYC-1.
   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         st_q        <= ST_IDLE;
         cycle_count <= '0;
         run_cycles  <= '0;
         fail_code   <= '0;
         fail_ch     <= '0;
      end else begin
         st_q        <= st_d;
         cycle_count <= inc(cycle_count);
         if (run && st_d == ST_RUN) run_cycles <= inc(run_cycles);
         if (run && st_d == ST_FAIL) begin
            fail_code <= fail_data;
            fail_ch   <= fail_idx;
         end
      end
   end

endmodule

// File: doc/tb_multi_pass_monitor.md
Name: tb_multi_pass_monitor

Overview:
- Parametrised testbench monitor, successor to the single-core pass detector.
- Watches N_CH core commit/fetch streams plus tohost-style scratch writes and classifies the run as PASS, FAIL or TIMEOUT.
- Collects per-channel performance counters: retired instructions, fetch handshakes, first-tohost timestamp.
- Instantiated in tb_top alongside the DUT; signals arrive as ports, not hierarchical references.

Parameters:
- N_CH, 2: number of monitored cores/harts.
- CNT_W, 32: width of every counter and timestamp.
- DATA_W, 32: width of the tohost write data.
- PASS_CODE, 1: tohost value meaning pass. Any other nonzero value means fail.
- TIMEOUT_CYC, 1000000: run-cycle limit. 0 disables the timeout.

Ports:
- tb_clk  in  1  testbench clock.
- tb_rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  arms the monitor; IDLE->RUN.
- cmt_valid  in  N_CH  per-channel instruction-commit valid.
- tohost_wr  in  N_CH  per-channel scratch/tohost write enable.
- tohost_data  in  N_CH*DATA_W  per-channel write data; channel c in bits [c*DATA_W +: DATA_W].
- ifu_valid  in  N_CH  fetch valid.
- ifu_ready  in  N_CH  fetch ready.
- state  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT.
- done  out  1  state is PASS, FAIL or TIMEOUT.
- cycle_count  out  CNT_W  cycles since reset release.
- run_cycles  out  CNT_W  cycles spent in RUN.
- ch_passed  out  N_CH  channel has written PASS_CODE.
- retire_cnt  out  N_CH*CNT_W  commits while the channel has not passed.
- fetch_cnt  out  N_CH*CNT_W  ifu_valid&ifu_ready while the channel has not passed.
- tohost_cnt  out  N_CH*CNT_W  qualifying tohost writes.
- tohost_cycle  out  N_CH*CNT_W  run_cycles value at the first qualifying write.
- fail_code  out  DATA_W  data of the first failing write.
- fail_ch  out  clog2(N_CH) (min 1)  channel of the first failing write.

Behaviour:
- Reset: all outputs 0; state IDLE; ch_passed 0.
- cycle_count increments every cycle after reset, in every state. All counters saturate at all-ones, never wrap.
- Qualifying write on channel c: tohost_wr[c] & cmt_valid[c] & state==RUN.
- Inputs are ignored in IDLE and in the terminal states. Counters and flags only change in RUN, except cycle_count.
- IDLE->RUN: on start==1. start in any other state is ignored. Next cycle state=RUN, run_cycles increments from 0.
- In RUN, per channel c, sampled with registered (1-cycle) latency:
  - retire_cnt[c] += cmt_valid[c] while !ch_passed[c].
  - fetch_cnt[c] += ifu_valid[c]&ifu_ready[c] while !ch_passed[c].
  - tohost_cnt[c] += 1 on every qualifying write, including after pass.
  - tohost_cycle[c] captured only on the first qualifying write.
  - A qualifying write with data==PASS_CODE sets ch_passed[c], sticky. The counters are not frozen on that same cycle; freezing starts the cycle after.
- RUN->FAIL: any qualifying write with data!=PASS_CODE and data!=0. Capture fail_code and fail_ch. If several channels fail on the same cycle, the lowest index wins.
- RUN->PASS: the cycle after ch_passed becomes all-ones, including the case where the final channels pass on the same cycle.
- RUN->TIMEOUT: when TIMEOUT_CYC!=0 and run_cycles==TIMEOUT_CYC-1 with no pass/fail decided.
- Priority on a simultaneous cycle: FAIL > PASS > TIMEOUT.
- Data==0 writes count in tohost_cnt and timestamp, but change no state.
- Terminal states hold until reset; all counters freeze. done=1 in terminal states.
- Reset asserted mid-run: immediate return to IDLE, all values cleared.

Decomposition:
- Package tb_mon_pkg holds:
  - state encoding localparams: ST_IDLE, ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT;
  - saturating-increment function sat_inc(CNT_W).
- Sub-module tb_mon_chan: one instance per channel via generate. It holds the passed flag, retire/fetch/tohost counters and the timestamp. It outputs pass_evt and fail_evt for the top-level FSM.

Test Plan:
- Reset then start at cycle 5; ch0 and ch1 commit every cycle; at run cycle 100 both write 1 -> ch_passed=2'b11, state PASS one cycle later, retire_cnt each 101, tohost_cycle each 100, done=1.
- ch0 writes 1 at run cycle 20, ch1 writes 1 at run cycle 50 -> ch0 retire/fetch frozen at 21 while ch1 continues to 51, PASS after cycle 50.
- ch1 writes 0x0000_0007 at cycle 30 while ch0 writes 1 the same cycle -> FAIL, fail_code=7, fail_ch=1, ch_passed[0]=1.
- TIMEOUT_CYC=64, no tohost writes -> state TIMEOUT with run_cycles=63; timeout with TIMEOUT_CYC=0 never fires over 10000 cycles.
- Tohost write and commits issued before start -> all counters 0, state IDLE; then tb_rst_n pulsed low mid-RUN -> all outputs 0 asynchronously, state IDLE.
- CNT_W=4, 20 consecutive commits -> retire_cnt saturates at 15, no wrap.
